mix_columns_seq: RTL

Sequential, parametrised MixColumns engine for the AES datapath. It accepts a full state over a valid/ready handshake and processes one 32-bit column per clock through a single shared GF(2^8) column unit. A latched mode bit selects forward MixColumns or InvMixColumns, so one instance serves both the encrypt and decrypt round pipelines. The result is held on a valid/ready output port until it is consumed.

---
 rtl/mix_columns_seq_if.sv | 23 ++
 rtl/mix_columns_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the MixColumns engine: state-in channel (with mode) and result-out channel.
// The producer/consumer side uses master; the engine uses slave.
interface mix_columns_seq_if #(
    parameter int LENGTH = 128
);
    logic              in_valid;
    logic              in_ready;
    logic              inv;
    logic [LENGTH-1:0] in;
    logic              out_valid;
    logic              out_ready;
    logic [LENGTH-1:0] out;

    modport master (
        output in_valid, inv, in, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, inv, in, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES (Inv)MixColumns: one column per clock through a shared GF(2^8) unit, COLS cycles per block.
// Result held on out until out_ready; in_ready only in IDLE or when DONE is being drained (back-to-back accept).
module mix_columns_seq #(
    parameter int BYTE   = 8,
    parameter int DWORD  = 32,
    parameter int LENGTH = 128,
    parameter int COLS   = LENGTH / DWORD
) (
    input  logic             clk,
    input  logic             rst_n,
    mix_columns_seq_if.slave bus
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              live;
    logic [CW-1:0]     cnt;
    logic [LENGTH-1:0] work;
    logic [LENGTH-1:0] work_mix;
    logic [LENGTH-1:0] result;
    logic              mode;
    logic              rdy;
    logic              vld;
    logic              accept;
    logic              last;
    logic [DWORD-1:0]  col_cur;
    logic [DWORD-1:0]  col_mix;

    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] x);
        return {x[BYTE-2:0], 1'b0} ^ (x[BYTE-1] ? 8'h1B : 8'h00);
    endfunction

    // Coefficients are built from x, 2x, 4x, 8x so both directions share one doubling chain.
    function automatic logic [DWORD-1:0] mix_col(input logic [DWORD-1:0] c, input logic md);
        logic [BYTE-1:0] a  [4];
        logic [BYTE-1:0] x2 [4];
        logic [BYTE-1:0] x4 [4];
        logic [BYTE-1:0] x8 [4];
        logic [BYTE-1:0] b  [4];
        logic [DWORD-1:0] r;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[DWORD-1-BYTE*i -: BYTE];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (!md) begin
                b[i] = x2[i]
                     ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ a[(i+2)%4]
                     ^ a[(i+3)%4];
            end else begin
                b[i] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
            end
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[DWORD-1-BYTE*i -: BYTE] = b[i];
        end
        return r;
    endfunction

    assign accept  = bus.in_valid && rdy;
    assign last    = (cnt == CW'(COLS - 1));
    assign col_cur = work[cnt*DWORD +: DWORD];
    assign col_mix = mix_col(col_cur, mode);

    always_comb begin
        work_mix                         = work;
        work_mix[cnt*DWORD +: DWORD]     = col_mix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // live keeps in_ready low while reset is held, rising on the first edge after release.
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        vld       = 1'b0;
        case (state)
            IDLE: begin
                rdy = live;
                if (bus.in_valid && live) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                vld = 1'b1;
                rdy = bus.out_ready;
                if (bus.out_ready) begin
                    state_nxt = bus.in_valid ? BUSY : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= 1'b0;
            cnt    <= '0;
            work   <= '0;
            mode   <= 1'b0;
            result <= '0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                work <= bus.in;
                mode <= bus.inv;
                cnt  <= '0;
            end else if (state == BUSY) begin
                work <= work_mix;
                if (last) begin
                    result <= work_mix;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // result is a separate register so out stays put while the next block is in flight.
    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out       = result;

endmodule
